// File: rtl/reloj_soc_pio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reloj_soc_pio_pkg                                                    |
// | Register addresses and edge-mode encodings for the button PIO.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package reloj_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/reloj_soc_debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reloj_soc_debounce_bit                                               |
// | Two-flop synchroniser and stability counter for one input channel.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reloj_soc_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic IDLE            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic deb_o
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      deb_q   <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule
`default_nettype wire

// File: rtl/reloj_soc_button_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reloj_soc_button_capture                                             |
// | Avalon-MM PIO slave: debounced inputs, edge capture, masked IRQ.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reloj_soc_button_capture
  import reloj_soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_dly_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] evt, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    reloj_soc_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE            (IDLE_LEVEL[i])
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .din_i (in_port[i]),
      .deb_o (deb[i])
    );
  end

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & write;

  always_comb begin
    evt = '0;
    if (EDGE_MODE == EDGE_FALL) begin
      evt = ~deb & deb_dly_q;
    end else if (EDGE_MODE == EDGE_ANY) begin
      evt = deb ^ deb_dly_q;
    end else begin
      evt = deb & ~deb_dly_q;
    end
  end

  always_comb begin
    clr       = '0;
    irqmask_d = irqmask_q;
    if (wr_en && address == ADDR_EDGECAP) begin
      clr = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_IRQMASK) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    // OR-ing the event after the clear lets a coincident set win
    edgecap_d = (edgecap_q & ~clr) | evt;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_dly_q  <= IDLE_LEVEL;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      deb_dly_q  <= deb;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_reloj_soc_button_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reloj_soc_button_capture                                          |
// | Directed vector bench for the button capture PIO slave.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reloj_soc_button_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic [3:0]  in0, in2, in3;
  logic [31:0] rd0, rd2, rd3;
  logic        irq0, irq2, irq3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reloj_soc_button_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .IDLE_LEVEL(4'h0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  reloj_soc_button_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .IDLE_LEVEL(4'h0)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  reloj_soc_button_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .IDLE_LEVEL(4'hF)) dut3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
    .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  din;
    int          cyc;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic cs, input logic wr, input logic [31:0] wd);
    address    = a;
    chipselect = cs;
    write      = wr;
    writedata  = wd;
  endtask

  initial begin
    reset = 1'b1;
    bus(2'd0, 1'b0, 1'b0, 32'h0);
    in0 = 4'h0; in2 = 4'h0; in3 = 4'hF;

    //          addr  cs  wr   wdata        din  cyc  exp_rd      irq
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h0, 2, 32'h0, 1'b0}); // idle after reset
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h5, 8, 32'h5, 1'b0}); // filtered data
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'h5, 1'b0}); // rises captured
    vt.push_back('{2'd3, 1'b1, 1'b1, 32'hF,        4'h5, 1, 32'h5, 1'b0}); // clear all
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'h0, 1'b0});
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h0, 8, 32'h0, 1'b0}); // falls
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h0, 1, 32'h0, 1'b0}); // falls ignored
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h1, 3, 32'h0, 1'b0}); // 3-cycle glitch
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h0, 8, 32'h0, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h0, 1, 32'h0, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h1, 4, 32'h0, 1'b0}); // 4-cycle pulse
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h0, 4, 32'h1, 1'b0});
    vt.push_back('{2'd3, 1'b1, 1'b1, 32'h1,        4'h0, 1, 32'h1, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h0, 1, 32'h0, 1'b0});
    vt.push_back('{2'd2, 1'b1, 1'b1, 32'h1,        4'h0, 1, 32'h0, 1'b0}); // irqmask = 1
    vt.push_back('{2'd2, 1'b0, 1'b0, 32'h0,        4'h0, 1, 32'h1, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h1, 7, 32'h0, 1'b1}); // irq at edge 7
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h1, 1, 32'h1, 1'b1});
    vt.push_back('{2'd3, 1'b1, 1'b1, 32'h1,        4'h1, 1, 32'h1, 1'b0}); // W1C drops irq
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h1, 1, 32'h0, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h5, 6, 32'h0, 1'b0}); // bit 2 rising
    vt.push_back('{2'd3, 1'b1, 1'b1, 32'h4,        4'h5, 1, 32'h0, 1'b0}); // clear meets set
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'h4, 1'b0}); // set wins
    vt.push_back('{2'd3, 1'b1, 1'b1, 32'h4,        4'h5, 1, 32'h4, 1'b0});
    vt.push_back('{2'd3, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'h0, 1'b0});
    vt.push_back('{2'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 4'h5, 1, 32'h1, 1'b0});
    vt.push_back('{2'd2, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'hF, 1'b0}); // upper bits 0
    vt.push_back('{2'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 4'h5, 1, 32'h0, 1'b0}); // reserved
    vt.push_back('{2'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 4'h5, 1, 32'h5, 1'b0}); // data is RO
    vt.push_back('{2'd0, 1'b0, 1'b0, 32'h0,        4'h5, 1, 32'h5, 1'b0});

    tick(3);
    chk("reset_rd0", rd0, 32'h0);
    chk("reset_irq0", {31'h0, irq0}, 32'h0);
    chk("reset_rd3", rd3, 32'h0);
    reset = 1'b0;

    foreach (vt[i]) begin
      bus(vt[i].addr, vt[i].cs, vt[i].wr, vt[i].wd);
      in0 = vt[i].din;
      tick(vt[i].cyc);
      chk($sformatf("vec%0d_rd", i), rd0, vt[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq0}, {31'h0, vt[i].exp_irq});
    end
    bus(2'd3, 1'b0, 1'b0, 32'h0);

    // Reset mid-debounce, then the held input is seen as a fresh change
    in0 = 4'h2;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("midrst_rd0", rd0, 32'h0);
    chk("midrst_irq0", {31'h0, irq0}, 32'h0);
    reset = 1'b0;
    tick(9);
    chk("postrst_ec0", rd0, 32'h2);

    // Any-edge mode
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus(2'd2, 1'b1, 1'b1, 32'h2);
    tick(1);
    bus(2'd3, 1'b0, 1'b0, 32'h0);
    tick(1);
    in2 = 4'h2;
    tick(7);
    chk("any_rise_rd", rd2, 32'h0);
    chk("any_rise_irq", {31'h0, irq2}, 32'h1);
    tick(1);
    chk("any_rise_ec", rd2, 32'h2);
    bus(2'd3, 1'b1, 1'b1, 32'h2);
    tick(1);
    chk("any_clr_irq", {31'h0, irq2}, 32'h0);
    bus(2'd3, 1'b0, 1'b0, 32'h0);
    tick(1);
    chk("any_clr_ec", rd2, 32'h0);
    in2 = 4'h0;
    tick(7);
    chk("any_fall_irq", {31'h0, irq2}, 32'h1);
    tick(1);
    chk("any_fall_ec", rd2, 32'h2);
    in2 = 4'h2;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("any_midrst_rd", rd2, 32'h0);
    chk("any_midrst_irq", {31'h0, irq2}, 32'h0);

    // Idle-high channels, falling-edge mode
    tick(1);
    reset = 1'b0;
    in2 = 4'h0;
    tick(10);
    chk("idle_hi_ec", rd3, 32'h0);
    chk("idle_hi_irq", {31'h0, irq3}, 32'h0);
    in3 = 4'h7;
    tick(8);
    chk("fall_ec3", rd3, 32'h8);
    bus(2'd0, 1'b0, 1'b0, 32'h0);
    tick(1);
    chk("fall_data3", rd3, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
